// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle between the ALU/load producers and wb_port_arbiter.
// The arbiter connects through the slave modport; producers and observers use master.
interface wb_port_arbiter_if #(
  parameter int unsigned LQ_DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          alu_ready;
  logic          ld_issue;
  logic [4:0]    ld_issue_rd;
  logic          ld_valid;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          wr_en;
  logic [4:0]    wr_rd;
  logic [31:0]   wr_data;
  logic [31:0]   busy_mask;
  logic [CW-1:0] lq_count;
  logic          fwd_valid;
  logic [4:0]    fwd_rd;
  logic [31:0]   fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready,
    input  wr_en, wr_rd, wr_data, busy_mask, lq_count,
    input  fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready,
    output wr_en, wr_rd, wr_data, busy_mask, lq_count,
    output fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Merges ALU results and queued load results onto the single register-file write port,
// with a load-busy scoreboard. Define WB_BYPASS_EN to expose the current winner on fwd_*.
module wb_port_arbiter #(
  parameter int unsigned LQ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  wb_port_arbiter_if.slave   bus
);
  localparam int unsigned PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LQ
  } src_e;

  logic [4:0]    q_rd   [LQ_DEPTH];
  logic [31:0]   q_data [LQ_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;
  logic          wr_en_q;
  logic [4:0]    wr_rd_q;
  logic [31:0]   wr_data_q;

  logic          lq_empty;
  logic          lq_full;
  logic          alu_elig;
  logic          enq;
  logic          deq;
  src_e          src;
  logic [4:0]    win_rd;
  logic [31:0]   win_data;
  logic          win_commit;

  // Grant: queue head preempts the ALU when the ALU is stalled, the queue is full,
  // or the ALU has used up its run of consecutive grants.
  always_comb begin
    lq_empty = (count == '0);
    lq_full  = (count == CW'(LQ_DEPTH));
    alu_elig = bus.alu_valid && !busy[bus.alu_rd];
    src      = SRC_NONE;
    if (!lq_empty && (!alu_elig || lq_full || starve_cnt == SW'(STARVE_LIMIT))) begin
      src = SRC_LQ;
    end else if (alu_elig) begin
      src = SRC_ALU;
    end
    win_rd   = '0;
    win_data = '0;
    case (src)
      SRC_LQ: begin
        win_rd   = q_rd[rd_ptr];
        win_data = q_data[rd_ptr];
      end
      SRC_ALU: begin
        win_rd   = bus.alu_rd;
        win_data = bus.alu_data;
      end
      default: ;
    endcase
    win_commit = (src != SRC_NONE) && (win_rd != '0);
    enq        = bus.ld_valid && !lq_full;
    deq        = (src == SRC_LQ);
  end

  // Clear before set so a same-edge issue to the retiring rd keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (deq) begin
      busy_nxt[win_rd] = 1'b0;
    end
    if (bus.ld_issue) begin
      busy_nxt[bus.ld_issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[wr_ptr]   <= bus.ld_rd;
      q_data[wr_ptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (lq_empty || src == SRC_LQ) begin
      starve_cnt <= '0;
    end else if (src == SRC_ALU && starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // An rd=0 winner is consumed but leaves wr_rd/wr_data untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      busy      <= '0;
    end else begin
      wr_en_q <= win_commit;
      if (win_commit) begin
        wr_rd_q   <= win_rd;
        wr_data_q <= win_data;
      end
      busy <= busy_nxt;
    end
  end

  assign bus.alu_ready = (src == SRC_ALU);
  assign bus.ld_ready  = !lq_full;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_rd     = wr_rd_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy_mask = busy;
  assign bus.lq_count  = count;

`ifdef WB_BYPASS_EN
  assign bus.fwd_valid = win_commit;
  assign bus.fwd_rd    = win_rd;
  assign bus.fwd_data  = win_data;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_rd    = '0;
  assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against a
// queue/array reference model of the write-port rules.
module tb_wb_port_arbiter;
  localparam int LQ_DEPTH     = 4;
  localparam int STARVE_LIMIT = 3;
  localparam int CW           = $clog2(LQ_DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.LQ_DEPTH(LQ_DEPTH)) bus ();

  wb_port_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit   [31:0] m_busy;
  int          m_starve;
  bit          m_wr_en;
  logic [4:0]  m_wr_rd;
  logic [31:0] m_wr_data;
  logic [31:0] obs_rf [32];

  always @(posedge clk) begin
    if (!reset && bus.wr_en) obs_rf[bus.wr_rd] <= bus.wr_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic bit m_alu_ok();
    return bus.alu_valid && (bus.alu_rd == 5'd0 || !m_busy[bus.alu_rd]);
  endfunction

  function automatic bit m_lq_win();
    return mq.size() != 0 &&
           (!m_alu_ok() || mq.size() == LQ_DEPTH || m_starve == STARVE_LIMIT);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_busy    = '0;
    m_starve  = 0;
    m_wr_en   = 1'b0;
    m_wr_rd   = '0;
    m_wr_data = '0;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.ld_issue    = 1'b0;
    bus.ld_issue_rd = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_data     = '0;
  endtask

  // Advance one clock; the model absorbs this cycle's inputs at the edge.
  task automatic tick();
    bit   lw, aw, enq, iss;
    ent_t w, e;
    logic [4:0] irs;
    lw  = m_lq_win();
    aw  = !lw && m_alu_ok();
    enq = bus.ld_valid && mq.size() < LQ_DEPTH;
    e.rd = bus.ld_rd;
    e.data = bus.ld_data;
    iss = bus.ld_issue;
    irs = bus.ld_issue_rd;
    if (lw) w = mq[0];
    else begin
      w.rd = bus.alu_rd;
      w.data = bus.alu_data;
    end
    @(posedge clk);
    if (mq.size() == 0 || lw) m_starve = 0;
    else if (aw && m_starve < STARVE_LIMIT) m_starve++;
    if (lw) begin
      void'(mq.pop_front());
      if (w.rd != 0) m_busy[w.rd] = 1'b0;
    end
    if (enq) mq.push_back(e);
    if (iss && irs != 0) m_busy[irs] = 1'b1;
    if ((lw || aw) && w.rd != 0) begin
      m_wr_en   = 1'b1;
      m_wr_rd   = w.rd;
      m_wr_data = w.data;
    end else begin
      m_wr_en = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    n_vec++; if (bus.wr_rd !== 5'd0) begin n_err++; $display("FAIL reset_wr_rd: got %0d want 0", bus.wr_rd); end
    n_vec++; if (bus.wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
    n_vec++; if (bus.busy_mask !== 32'd0) begin n_err++; $display("FAIL reset_busy: got %h want 0", bus.busy_mask); end
    n_vec++; if (bus.lq_count !== CW'(0)) begin n_err++; $display("FAIL reset_lq_count: got %0d want 0", bus.lq_count); end
    n_vec++; if (bus.fwd_valid !== 1'b0) begin n_err++; $display("FAIL reset_fwd_valid: got %b want 0", bus.fwd_valid); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_midstream();
    idle();
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd2; tick();
    bus.ld_issue_rd = 5'd5; tick();
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h0000_0101;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd2; bus.ld_data = 32'h22; tick();
    bus.ld_rd = 5'd5; bus.ld_data = 32'h55; tick();
    idle();
    #1;
    n_vec++; if (bus.lq_count !== CW'(2)) begin n_err++; $display("FAIL mid_lq_count: got %0d want 2", bus.lq_count); end
    n_vec++; if (bus.busy_mask !== 32'h0000_0024) begin n_err++; $display("FAIL mid_busy: got %h want 00000024", bus.busy_mask); end
    reset = 1'b1;
    #1;
    m_reset();
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_wr_en: got %b want 0", bus.wr_en); end
    n_vec++; if (bus.wr_rd !== 5'd0 || bus.wr_data !== 32'd0) begin n_err++; $display("FAIL mid_rst_wr: got rd %0d data %h want 0/0", bus.wr_rd, bus.wr_data); end
    n_vec++; if (bus.lq_count !== CW'(0) || bus.busy_mask !== 32'd0) begin n_err++; $display("FAIL mid_rst_state: got cnt %0d busy %h want 0/0", bus.lq_count, bus.busy_mask); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h11;
    @(posedge clk); #1;
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_no_write: got %b want 0", bus.wr_en); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL mid_alu_ready: got %b want 1", bus.alu_ready); end
    tick();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd5 || bus.wr_data !== 32'h11) begin n_err++; $display("FAIL mid_post_write: got en %b rd %0d data %h want 1/5/00000011", bus.wr_en, bus.wr_rd, bus.wr_data); end
    idle();
    tick();
  endtask

  task automatic test_alu_only();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hDEADBEEF;
    #1;
    n_vec++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b want 1", bus.alu_ready); end
    tick();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd3 || bus.wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_write: got en %b rd %0d data %h want 1/3/deadbeef", bus.wr_en, bus.wr_rd, bus.wr_data); end
    bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    #1;
    n_vec++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_x0_ready: got %b want 1", bus.alu_ready); end
    tick();
    n_vec++; if (bus.wr_en !== 1'b0 || bus.wr_rd !== 5'd3 || bus.wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_x0_hold: got en %b rd %0d data %h want 0/3/deadbeef", bus.wr_en, bus.wr_rd, bus.wr_data); end
    idle();
    tick();
  endtask

  task automatic test_load_hazard();
    idle();
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7; tick();
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'hA5A5_0007;
    #1;
    n_vec++; if (bus.busy_mask[7] !== 1'b1) begin n_err++; $display("FAIL haz_busy_set: got %b want 1", bus.busy_mask[7]); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h55; #1; end
      n_vec++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL haz_stall%0d: got %b want 0", i, bus.alu_ready); end
      tick();
    end
    bus.ld_valid = 1'b0;
    #1;
    n_vec++; if (bus.alu_ready !== 1'b0 || bus.lq_count !== CW'(1)) begin n_err++; $display("FAIL haz_lq_turn: got rdy %b cnt %0d want 0/1", bus.alu_ready, bus.lq_count); end
    tick();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd7 || bus.wr_data !== 32'h55 || bus.busy_mask[7] !== 1'b0) begin n_err++; $display("FAIL haz_ld_commit: got en %b rd %0d data %h busy7 %b want 1/7/55/0", bus.wr_en, bus.wr_rd, bus.wr_data, bus.busy_mask[7]); end
    #1;
    n_vec++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL haz_alu_release: got %b want 1", bus.alu_ready); end
    tick();
    n_vec++; if (bus.wr_data !== 32'hA5A5_0007) begin n_err++; $display("FAIL haz_alu_follow: got %h want a5a50007", bus.wr_data); end
    idle();
    tick();
    n_vec++; if (obs_rf[7] !== 32'hA5A5_0007) begin n_err++; $display("FAIL haz_final_rf: got %h want a5a50007", obs_rf[7]); end
  endtask

  task automatic test_starvation();
    int grants;
    idle();
    grants = 0;
    bus.alu_valid = 1'b1;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd10; bus.ld_data = 32'h1010;
    for (int i = 0; i < 4; i++) begin
      bus.alu_rd = 5'(i + 1); bus.alu_data = 32'(i);
      #1;
      if (bus.alu_ready === 1'b1) grants++;
      tick();
      bus.ld_valid = 1'b0;
    end
    n_vec++; if (grants != 4) begin n_err++; $display("FAIL starve_alu_grants: got %0d want 4", grants); end
    bus.alu_rd = 5'd4;
    #1;
    n_vec++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL starve_preempt: got %b want 0", bus.alu_ready); end
    tick();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd10 || bus.wr_data !== 32'h1010) begin n_err++; $display("FAIL starve_ld_commit: got en %b rd %0d data %h want 1/10/1010", bus.wr_en, bus.wr_rd, bus.wr_data); end
    idle();
    tick();
  endtask

  task automatic test_full_queue();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h4444;
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ld_rd = 5'(11 + i); bus.ld_data = 32'(32'hF00 + i);
      tick();
    end
    bus.ld_rd = 5'd15; bus.ld_data = 32'hBAD;
    #1;
    n_vec++; if (bus.lq_count !== CW'(4) || bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL full_state: got cnt %0d rdy %b want 4/0", bus.lq_count, bus.ld_ready); end
    n_vec++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL full_head_wins: got %b want 0", bus.alu_ready); end
    tick();
    bus.ld_valid = 1'b0;
    n_vec++; if (bus.ld_ready !== 1'b1 || bus.lq_count !== CW'(3) || bus.wr_rd !== 5'd11) begin n_err++; $display("FAIL full_after_deq: got rdy %b cnt %0d rd %0d want 1/3/11", bus.ld_ready, bus.lq_count, bus.wr_rd); end
    bus.alu_valid = 1'b0;
    for (int i = 0; i < 10 && mq.size() != 0; i++) tick();
    n_vec++; if (bus.lq_count !== CW'(0) || mq.size() != 0) begin n_err++; $display("FAIL full_drain: got cnt %0d want 0", bus.lq_count); end
  endtask

  task automatic test_same_edge();
    idle();
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9; tick();
    bus.ld_issue = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h99; tick();
    bus.ld_valid = 1'b0;
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9;
    tick();
    bus.ld_issue = 1'b0;
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd9 || bus.wr_data !== 32'h99) begin n_err++; $display("FAIL same_edge_commit: got en %b rd %0d data %h want 1/9/99", bus.wr_en, bus.wr_rd, bus.wr_data); end
    n_vec++; if (bus.busy_mask[9] !== 1'b1) begin n_err++; $display("FAIL same_edge_busy: got %b want 1", bus.busy_mask[9]); end
  endtask

  task automatic test_random();
    bit         lw, aw, exp_fv;
    logic [4:0] exp_frd;
    logic [31:0] exp_fdata;
    for (int c = 0; c < 3000; c++) begin
      bus.alu_valid   = ($urandom_range(0, 3) != 0);
      bus.alu_rd      = 5'($urandom_range(0, 15));
      bus.alu_data    = $urandom;
      bus.ld_issue    = ($urandom_range(0, 3) == 0);
      bus.ld_issue_rd = 5'($urandom_range(0, 15));
      bus.ld_valid    = ($urandom_range(0, 2) == 0);
      bus.ld_rd       = 5'($urandom_range(0, 15));
      bus.ld_data     = $urandom;
      #1;
      lw = m_lq_win();
      aw = !lw && m_alu_ok();
      exp_frd   = lw ? mq[0].rd : bus.alu_rd;
      exp_fdata = lw ? mq[0].data : bus.alu_data;
`ifdef WB_BYPASS_EN
      exp_fv = (lw || aw) && exp_frd != 0;
`else
      exp_fv = 1'b0;
`endif
      n_vec++; if (bus.alu_ready !== aw) begin n_err++; $display("FAIL rnd_alu_ready c%0d: got %b want %b", c, bus.alu_ready, aw); end
      n_vec++; if (bus.ld_ready !== (mq.size() != LQ_DEPTH) || bus.lq_count !== CW'(mq.size())) begin n_err++; $display("FAIL rnd_queue c%0d: got rdy %b cnt %0d want cnt %0d", c, bus.ld_ready, bus.lq_count, mq.size()); end
      n_vec++; if (bus.busy_mask !== m_busy) begin n_err++; $display("FAIL rnd_busy c%0d: got %h want %h", c, bus.busy_mask, m_busy); end
      n_vec++; if (bus.wr_en !== m_wr_en || bus.wr_rd !== m_wr_rd || bus.wr_data !== m_wr_data) begin n_err++; $display("FAIL rnd_wr c%0d: got %b/%0d/%h want %b/%0d/%h", c, bus.wr_en, bus.wr_rd, bus.wr_data, m_wr_en, m_wr_rd, m_wr_data); end
      n_vec++; if (bus.fwd_valid !== exp_fv || (exp_fv && (bus.fwd_rd !== exp_frd || bus.fwd_data !== exp_fdata))) begin n_err++; $display("FAIL rnd_fwd c%0d: got %b/%0d/%h want %b/%0d/%h", c, bus.fwd_valid, bus.fwd_rd, bus.fwd_data, exp_fv, exp_frd, exp_fdata); end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_reset_midstream();
    test_alu_only();
    test_load_hazard();
    test_starvation();
    test_full_queue();
    test_same_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
